// File: rtl/u110_ata_cycle_pkg.sv
// State encoding and PIO timing constants for the ATA cycle engine.
// Mode 0 and mode 4 lengths are in CLK40 periods.
package u110_ata_cycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_WAIT_RDY,
    ST_HOLD,
    ST_ACK,
    ST_RECOVER
  } state_t;

  localparam int CNT_W = 6;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t T_SETUP_M0   = 6'd3;
  localparam cnt_t T_SETUP_M4   = 6'd1;
  localparam cnt_t T_ACTIVE_M0  = 6'd12;
  localparam cnt_t T_ACTIVE_M4  = 6'd3;
  localparam cnt_t T_RECOVER_M0 = 6'd9;
  localparam cnt_t T_RECOVER_M4 = 6'd3;
  localparam cnt_t T_TIMEOUT    = 6'd48;

  // Value loaded into the timing counter on entry to a state.
  function automatic cnt_t f_state_len(input state_t st, input logic fast);
    cnt_t len;
    case (st)
      ST_SETUP:        len = fast ? T_SETUP_M4 : T_SETUP_M0;
      ST_ACTIVE:       len = fast ? T_ACTIVE_M4 : T_ACTIVE_M0;
      ST_WAIT_RDY:     len = T_TIMEOUT;
      ST_HOLD, ST_ACK: len = 6'd1;
      ST_RECOVER:      len = fast ? T_RECOVER_M4 : T_RECOVER_M0;
      default:         len = '0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/u110_ata_cycle_if.sv
// CPU-side request and ATA-side strobe/buffer signals of the ATA cycle engine.
interface u110_ata_cycle_if;

  logic ts_n;
  logic ata_en_n;
  logic rnw;
  logic ata_fast;
  logic iordy;
  logic dior_n;
  logic diow_n;
  logic buf_oe_n;
  logic buf_dir;
  logic data_le;
  logic tack;
  logic timeout;
  logic busy;

  modport master (
    output ts_n, ata_en_n, rnw, ata_fast, iordy,
    input  dior_n, diow_n, buf_oe_n, buf_dir, data_le, tack, timeout, busy
  );

  modport slave (
    input  ts_n, ata_en_n, rnw, ata_fast, iordy,
    output dior_n, diow_n, buf_oe_n, buf_dir, data_le, tack, timeout, busy
  );

endinterface

// File: rtl/u110_ata_cycle_sync2.sv
// Two-flop synchronizer for the asynchronous IORDY input.
module u110_ata_cycle_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/u110_ata_cycle.sv
// ATA PIO cycle sequencer: one 68040 transfer start produces one strobed ATA
// access and a single ATA_TACK pulse; all outputs come straight from flops.
//
// state     | meaning
// IDLE      | waiting for TSn & ATA_ENn
// SETUP     | buffer enabled, address setup before strobe
// ACTIVE    | DIORn/DIOWn asserted for the mode's strobe width
// WAIT_RDY  | strobe stretched while IORDY low, bounded by T_TIMEOUT
// HOLD      | strobe released, read data latched
// ACK       | ATA_TACK pulse to the termination stage
// RECOVER   | bus recovery before the next start is accepted
module u110_ata_cycle
  import u110_ata_cycle_pkg::*;
(
  input  logic             i_clk40,
  input  logic             i_reset,
  u110_ata_cycle_if.slave  bus
);

  state_t r_state, w_state_nxt;
  cnt_t   r_cnt, w_cnt_nxt;
  logic   r_rnw, r_fast, r_tmo;
  logic   w_rnw_nxt, w_fast_nxt, w_tmo_nxt;
  logic   w_start, w_last, w_iordy_s;

  logic r_dior_n, r_diow_n, r_oe_n, r_dir, r_le, r_tack, r_tmo_o, r_busy;
  logic w_dior_n, w_diow_n, w_oe_n, w_dir, w_le, w_tack, w_tmo_o, w_busy;

  u110_ata_cycle_sync2 u_sync_iordy (
    .i_clk (i_clk40),
    .i_rst (i_reset),
    .i_d   (bus.iordy),
    .o_q   (w_iordy_s)
  );

  assign w_start    = (r_state == ST_IDLE) && !bus.ts_n && !bus.ata_en_n;
  assign w_last     = (r_cnt == 6'd1);
  assign w_rnw_nxt  = w_start ? bus.rnw      : r_rnw;
  assign w_fast_nxt = w_start ? bus.ata_fast : r_fast;

  always_ff @(posedge i_clk40) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_rnw    <= 1'b1;
      r_fast   <= 1'b0;
      r_tmo    <= 1'b0;
      r_dior_n <= 1'b1;
      r_diow_n <= 1'b1;
      r_oe_n   <= 1'b1;
      r_dir    <= 1'b1;
      r_le     <= 1'b0;
      r_tack   <= 1'b0;
      r_tmo_o  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rnw    <= w_rnw_nxt;
      r_fast   <= w_fast_nxt;
      r_tmo    <= w_tmo_nxt;
      r_dior_n <= w_dior_n;
      r_diow_n <= w_diow_n;
      r_oe_n   <= w_oe_n;
      r_dir    <= w_dir;
      r_le     <= w_le;
      r_tack   <= w_tack;
      r_tmo_o  <= w_tmo_o;
      r_busy   <= w_busy;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SETUP;
          w_tmo_nxt   = 1'b0;
        end
      end
      ST_SETUP:    if (w_last) w_state_nxt = ST_ACTIVE;
      ST_ACTIVE:   if (w_last) w_state_nxt = w_iordy_s ? ST_HOLD : ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (w_iordy_s) begin
          w_state_nxt = ST_HOLD;
        end else if (w_last) begin
          w_state_nxt = ST_HOLD;
          w_tmo_nxt   = 1'b1;
        end
      end
      ST_HOLD:     w_state_nxt = ST_ACK;
      ST_ACK:      w_state_nxt = ST_RECOVER;
      ST_RECOVER:  if (w_last) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
    // Counter reloads on every state change and saturates at zero.
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = f_state_len(w_state_nxt, w_fast_nxt);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - 6'd1;
    end
  end

  // Outputs decoded from the next state so the registered copies line up with it.
  always_comb begin
    w_dior_n = 1'b1;
    w_diow_n = 1'b1;
    w_oe_n   = 1'b1;
    w_dir    = 1'b1;
    w_le     = 1'b0;
    w_tack   = 1'b0;
    w_tmo_o  = 1'b0;
    w_busy   = (w_state_nxt != ST_IDLE);
    case (w_state_nxt)
      ST_SETUP: begin
        w_oe_n = 1'b0;
        w_dir  = w_rnw_nxt;
      end
      ST_ACTIVE, ST_WAIT_RDY: begin
        w_oe_n   = 1'b0;
        w_dir    = w_rnw_nxt;
        w_dior_n = !w_rnw_nxt;
        w_diow_n = w_rnw_nxt;
      end
      ST_HOLD: begin
        w_oe_n = 1'b0;
        w_dir  = w_rnw_nxt;
        w_le   = w_rnw_nxt;
      end
      ST_ACK: begin
        w_tack  = 1'b1;
        w_tmo_o = w_tmo_nxt;
      end
      default: ;
    endcase
  end

  assign bus.dior_n   = r_dior_n;
  assign bus.diow_n   = r_diow_n;
  assign bus.buf_oe_n = r_oe_n;
  assign bus.buf_dir  = r_dir;
  assign bus.data_le  = r_le;
  assign bus.tack     = r_tack;
  assign bus.timeout  = r_tmo_o;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_u110_ata_cycle.sv
// Bench for u110_ata_cycle: each started cycle pushes its expected profile,
// a negedge monitor measures the real cycle and compares when ATA_BUSY drops.
module tb_u110_ata_cycle;

  localparam int RDY_ALWAYS = -2;
  localparam int RDY_NEVER  = -1;

  logic clk40 = 1'b0;
  logic reset = 1'b1;

  always #5 clk40 = ~clk40;

  u110_ata_cycle_if bus_if ();

  u110_ata_cycle dut (
    .i_clk40 (clk40),
    .i_reset (reset),
    .bus     (bus_if)
  );

  typedef struct {
    int   busy_len;
    int   setup_len;
    int   rd_len;
    int   wr_len;
    int   le_cnt;
    int   tack_cnt;
    int   tmo_cnt;
    int   recov_len;
    logic dir;
    logic abort;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  int   m_busy, m_setup, m_rd, m_wr, m_both, m_le, m_tack, m_tmo, m_recov;
  int   m_stray = 0;
  logic m_dir, m_strobe_seen, m_tack_seen;
  logic m_prev_busy = 1'b0;
  exp_t m_e;

  always @(negedge clk40) begin
    if (bus_if.busy === 1'b1) begin
      if (!m_prev_busy) begin
        m_busy = 0; m_setup = 0; m_rd = 0; m_wr = 0; m_both = 0;
        m_le = 0; m_tack = 0; m_tmo = 0; m_recov = 0;
        m_dir = 1'b0; m_strobe_seen = 1'b0; m_tack_seen = 1'b0;
      end
      m_busy++;
      if (!bus_if.dior_n) m_rd++;
      if (!bus_if.diow_n) m_wr++;
      if (!bus_if.dior_n && !bus_if.diow_n) m_both++;
      if (!bus_if.dior_n || !bus_if.diow_n) begin
        if (!m_strobe_seen) m_dir = bus_if.buf_dir;
        m_strobe_seen = 1'b1;
      end else if (!m_strobe_seen && !bus_if.buf_oe_n) begin
        m_setup++;
      end
      if (m_tack_seen && !bus_if.tack) m_recov++;
      if (bus_if.tack) begin
        m_tack++;
        m_tack_seen = 1'b1;
      end
      if (bus_if.data_le) m_le++;
      if (bus_if.timeout) m_tmo++;
    end else if (bus_if.busy === 1'b0) begin
      if (!bus_if.dior_n || !bus_if.diow_n || bus_if.tack || bus_if.timeout ||
          bus_if.data_le || !bus_if.buf_oe_n) m_stray++;
    end
    if (bus_if.busy === 1'b0 && m_prev_busy) begin
      if (sb_q.size() == 0) begin
        check_val("unexpected_cycle", 1, 0);
      end else begin
        m_e = sb_q.pop_front();
        check_val("tack_count", m_tack, m_e.tack_cnt);
        check_val("both_strobes_low", m_both, 0);
        if (!m_e.abort) begin
          check_val("busy_len", m_busy, m_e.busy_len);
          check_val("setup_len", m_setup, m_e.setup_len);
          check_val("dior_len", m_rd, m_e.rd_len);
          check_val("diow_len", m_wr, m_e.wr_len);
          check_val("data_le_count", m_le, m_e.le_cnt);
          check_val("timeout_count", m_tmo, m_e.tmo_cnt);
          check_val("recover_len", m_recov, m_e.recov_len);
          check_val("buf_dir", m_dir, m_e.dir);
        end
      end
    end
    m_prev_busy = (bus_if.busy === 1'b1);
  end

  // rdy_at: clocks after the start edge at which IORDY rises (or RDY_*).
  // ts_a/ts_b: clocks at which a stray TSn/ATA_ENn pulse is driven (-1 none).
  task automatic run_cycle(input logic rnw, input logic fast, input int rdy_at,
                           input int ts_a, input int ts_b);
    exp_t e;
    int   s, a, r, w, k;
    logic tmo;
    s = fast ? 1 : 3;
    a = fast ? 3 : 12;
    r = fast ? 3 : 9;
    if (rdy_at == RDY_ALWAYS)     w = 0;
    else if (rdy_at == RDY_NEVER) w = 49;
    else                          w = rdy_at + 3 - s - a;
    if (w < 0) w = 0;
    tmo = (w > 48);
    if (tmo) w = 48;
    e.busy_len  = s + a + w + 2 + r;
    e.setup_len = s;
    e.rd_len    = rnw ? a + w : 0;
    e.wr_len    = rnw ? 0 : a + w;
    e.le_cnt    = rnw ? 1 : 0;
    e.tack_cnt  = 1;
    e.tmo_cnt   = tmo ? 1 : 0;
    e.recov_len = r;
    e.dir       = rnw;
    e.abort     = 1'b0;
    if (rdy_at != RDY_ALWAYS) begin
      bus_if.iordy = 1'b0;
      repeat (3) @(negedge clk40);
    end
    bus_if.ts_n     = 1'b0;
    bus_if.ata_en_n = 1'b0;
    bus_if.rnw      = rnw;
    bus_if.ata_fast = fast;
    sb_q.push_back(e);
    @(negedge clk40);
    bus_if.rnw      = !rnw;
    bus_if.ata_fast = !fast;
    k = 0;
    while (k < 300) begin
      if (k == rdy_at) bus_if.iordy = 1'b1;
      bus_if.ts_n     = !(k == ts_a || k == ts_b);
      bus_if.ata_en_n = bus_if.ts_n;
      @(negedge clk40);
      k++;
      if (!bus_if.busy) break;
    end
    check_val("cycle_completes", bus_if.busy, 0);
    bus_if.ts_n     = 1'b1;
    bus_if.ata_en_n = 1'b1;
    bus_if.iordy    = 1'b1;
    repeat (4) @(negedge clk40);
  endtask

  task automatic run_abort();
    exp_t e;
    e.busy_len = 0; e.setup_len = 0; e.rd_len = 0; e.wr_len = 0; e.le_cnt = 0;
    e.tack_cnt = 0; e.tmo_cnt = 0; e.recov_len = 0; e.dir = 1'b1; e.abort = 1'b1;
    bus_if.ts_n     = 1'b0;
    bus_if.ata_en_n = 1'b0;
    bus_if.rnw      = 1'b1;
    bus_if.ata_fast = 1'b0;
    sb_q.push_back(e);
    @(negedge clk40);
    bus_if.ts_n     = 1'b1;
    bus_if.ata_en_n = 1'b1;
    repeat (6) @(negedge clk40);
    check_val("abort_strobe_active", bus_if.dior_n, 0);
    reset = 1'b1;
    @(negedge clk40);
    check_val("abort_dior_n", bus_if.dior_n, 1);
    check_val("abort_diow_n", bus_if.diow_n, 1);
    check_val("abort_tack", bus_if.tack, 0);
    check_val("abort_busy", bus_if.busy, 0);
    check_val("abort_buf_oe_n", bus_if.buf_oe_n, 1);
    reset = 1'b0;
    repeat (30) @(negedge clk40);
    check_val("abort_stays_idle", bus_if.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.ts_n     = 1'b1;
    bus_if.ata_en_n = 1'b1;
    bus_if.rnw      = 1'b1;
    bus_if.ata_fast = 1'b0;
    bus_if.iordy    = 1'b1;
    reset           = 1'b1;
    repeat (3) @(negedge clk40);
    check_val("rst_dior_n", bus_if.dior_n, 1);
    check_val("rst_diow_n", bus_if.diow_n, 1);
    check_val("rst_buf_oe_n", bus_if.buf_oe_n, 1);
    check_val("rst_buf_dir", bus_if.buf_dir, 1);
    check_val("rst_data_le", bus_if.data_le, 0);
    check_val("rst_tack", bus_if.tack, 0);
    check_val("rst_timeout", bus_if.timeout, 0);
    check_val("rst_busy", bus_if.busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk40);

    // A start needs TSn and ATA_ENn together.
    bus_if.ts_n = 1'b0;
    @(negedge clk40);
    bus_if.ts_n     = 1'b1;
    bus_if.ata_en_n = 1'b0;
    @(negedge clk40);
    bus_if.ata_en_n = 1'b1;
    check_val("no_start_partial", bus_if.busy, 0);
    @(negedge clk40);
    check_val("no_start_partial_late", bus_if.busy, 0);

    run_cycle(1'b1, 1'b0, RDY_ALWAYS, -1, -1);
    run_cycle(1'b0, 1'b1, RDY_ALWAYS, -1, -1);
    run_cycle(1'b1, 1'b0, 22, -1, -1);
    run_cycle(1'b1, 1'b1, RDY_NEVER, -1, -1);
    run_cycle(1'b0, 1'b0, RDY_ALWAYS, 6, 25);
    run_cycle(1'b1, 1'b1, RDY_ALWAYS, 2, 8);
    run_cycle(1'b0, 1'b1, 5, -1, -1);
    run_abort();
    run_cycle(1'b1, 1'b0, RDY_ALWAYS, -1, -1);

    check_val("scoreboard_empty", sb_q.size(), 0);
    check_val("stray_idle_outputs", m_stray, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
